// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer: op codes, FSM states
// and small op-decoding helpers.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// on unsigned magnitudes.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] mul_next,
    output logic [WIDTH-1:0]   rem_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    // Multiply keeps {partial product, remaining multiplier bits} in acc;
    // divide keeps {partial remainder, dividend/quotient bits}.
    always_comb begin
        sum       = '0;
        rem_shift = '0;
        trial     = '0;
        mul_next  = acc;
        rem_next  = acc[2*WIDTH-1:WIDTH];
        q_bit     = 1'b0;
        if (is_div) begin
            rem_shift = acc[2*WIDTH-1:WIDTH-1];
            trial     = rem_shift - {1'b0, operand};
            // No borrow out of the trial subtraction means the divisor fits.
            q_bit     = ~trial[WIDTH];
            rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        end else begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
            mul_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle 32-bit signed/unsigned multiply/divide sequencer; one bit per cycle,
// 64-bit results in hi/lo, fixed latency for every op.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_e             state, state_next;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_orig, operand_q;
    logic [2*WIDTH-1:0] acc, mul_next;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;
    logic               accept, in_signed, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign in_signed = op_is_signed(op);
    assign a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;
    assign is_div    = op_is_div(op_q);
    assign busy      = (state == S_CALC) || (state == S_FIX);
    assign done      = (state == S_DONE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (operand_q),
        .is_div   (is_div),
        .mul_next (mul_next),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: if (count == CW'(WIDTH - 1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = start ? S_CALC : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Sign correction from the saved operand signs; remainder follows the dividend.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            op_q        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            a_orig      <= '0;
            operand_q   <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count       <= '0;
            op_q        <= op;
            sign_a      <= in_signed && a[WIDTH-1];
            sign_b      <= in_signed && b[WIDTH-1];
            a_orig      <= a;
            operand_q   <= b_mag;
            acc         <= {{WIDTH{1'b0}}, a_mag};
            div_by_zero <= 1'b0;
        end else if (state == S_CALC) begin
            count <= count + 1'b1;
            acc   <= is_div ? {rem_next, acc[WIDTH-2:0], q_bit} : mul_next;
        end else if (state == S_FIX) begin
            if (!is_div) begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
            end else if (operand_q == '0) begin
                hi          <= a_orig;
                lo          <= '1;
                div_by_zero <= 1'b1;
            end else begin
                hi <= rem_fix;
                lo <= quot_fix;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table plus hand-written
// sequences for ignored starts, back-to-back starts and mid-operation reset.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;
    vec_t vecs[10];

    muldiv_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Counts edges from the accepting edge until done is seen (bounded).
    task automatic waitDone(output int lat);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issues one start pulse; returns with done high (or after the bound expires).
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        checkOutput("busy_after_accept", {31'b0, busy}, 32'd1);
        checkOutput("dbz_cleared_on_accept", {31'b0, div_by_zero}, 32'd0);
        waitDone(lat);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{"mulu_7x6",      OP_MULU, 32'd7,        32'd6,        32'h0000_0000, 32'd42,        1'b0};
        vecs[1] = '{"mul_m3x5",      OP_MUL,  32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{"div_m7d2",      OP_DIV,  32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"divu_max_d16",  OP_DIVU, 32'hFFFF_FFFF, 32'h10,      32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[4] = '{"divu_100_d0",   OP_DIVU, 32'd100,      32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{"div_overflow",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       32'h8000_0000, 1'b0};
        vecs[6] = '{"mulu_max_sq",   OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[7] = '{"mul_min_sq",    OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0};
        vecs[8] = '{"div_7dm2",      OP_DIV,  32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{"div_m8d0",      OP_DIV,  32'hFFFF_FFF8, 32'd0,       32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_dbz", {31'b0, div_by_zero}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            checkOutput({vecs[i].name, "_latency"}, lat, 32'd34);
            checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            checkOutput({vecs[i].name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, vecs[i].exp_dbz});
            @(posedge clk); #1;
            checkOutput({vecs[i].name, "_done_pulse_ends"}, {31'b0, done}, 32'd0);
        end

        // Second start while busy must be ignored.
        @(posedge clk); #1;
        start = 1'b1; op = OP_MULU; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk); #1; lat++; end
        start = 1'b1; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        seen = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        checkOutput("ignored_start_latency", lat, 32'd34);
        checkOutput("ignored_start_lo", lo, 32'd6);

        // Back-to-back start accepted during DONE.
        checkOutput("b2b_done_in_accept_cycle", {31'b0, done}, 32'd1);
        start = 1'b1; op = OP_MULU; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
        checkOutput("b2b_hold_lo", lo, 32'd6);
        waitDone(lat);
        checkOutput("b2b_latency", lat, 32'd34);
        checkOutput("b2b_lo", lo, 32'd81);

        // Reset ten cycles into a divide aborts it without a done pulse.
        @(posedge clk); #1;
        start = 1'b1; op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checkOutput("abort_no_done", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
